// File: rtl/aes_round_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_controller_if
//  Description : Input handshake, output handshake and status bundle for the
//                iterative AES-128 encryption sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface aes_round_controller_if;
    logic         inValid;
    logic         inReady;
    logic [127:0] plainIn;
    logic [127:0] keyIn;
    logic         outValid;
    logic         outReady;
    logic [127:0] cipherOut;
    logic [3:0]   roundCount;
    logic         busy;

    // Producer/consumer side of the block
    modport master (
        output inValid, plainIn, keyIn, outReady,
        input  inReady, outValid, cipherOut, roundCount, busy
    );

    // The encryption sequencer itself
    modport slave (
        input  inValid, plainIn, keyIn, outReady,
        output inReady, outValid, cipherOut, roundCount, busy
    );
endinterface
`default_nettype wire

// File: rtl/aes_round_controller.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_controller
//  Description : Iterative AES-128 encryptor. One shared round datapath runs
//                the initial AddRoundKey plus ten rounds, one round per clock,
//                expanding the round key on the fly.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_round_controller (
    input  logic                   clock,
    input  logic                   nReset,
    aes_round_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } fsm_t;

    fsm_t         fsm_q,    fsm_d;
    logic [127:0] state_q,  state_d;
    logic [127:0] key_q,    key_d;
    logic [7:0]   rcon_q,   rcon_d;
    logic [3:0]   rc_q,     rc_d;
    logic [127:0] cipher_q, cipher_d;

    // ------------------------------------------------------------------
    // GF(2^8) helpers and the round primitives
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box built arithmetically: multiplicative inverse (a^254, 0 -> 0)
    // followed by the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x3, x7, x15, x31, x63, x127, inv;
        x3   = gf_mul(gf_mul(a, a), a);
        x7   = gf_mul(gf_mul(x3, x3), a);
        x15  = gf_mul(gf_mul(x7, x7), a);
        x31  = gf_mul(gf_mul(x15, x15), a);
        x63  = gf_mul(gf_mul(x31, x31), a);
        x127 = gf_mul(gf_mul(x63, x63), a);
        inv  = gf_mul(x127, x127);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte r+4c of the column-major state is row r, column c.
    function automatic logic [127:0] shift_row(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c+8 +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            o[32*c    +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c+8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

    // Word j occupies bits [32j+31:32j] with its byte 0 in the low bits, so
    // RotWord moves the low byte of word 3 to the top.
    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3, rot;
        rot = {k[103:96], k[127:104]};
        for (int i = 0; i < 4; i++) t[8*i +: 8] = sbox(rot[8*i +: 8]);
        t  = t ^ {24'h000000, rc};
        n0 = k[31:0]   ^ t;
        n1 = k[63:32]  ^ n0;
        n2 = k[95:64]  ^ n1;
        n3 = k[127:96] ^ n2;
        return {n3, n2, n1, n0};
    endfunction

    // ------------------------------------------------------------------
    // Shared round datapath
    // ------------------------------------------------------------------
    logic [127:0] w_nextKey;
    logic [127:0] w_shifted;
    logic [127:0] w_roundOut;
    logic [127:0] w_finalOut;

    assign w_nextKey  = next_key(key_q, rcon_q);
    assign w_shifted  = shift_row(sub_bytes(state_q));
    assign w_roundOut = add_round_key(mix_columns(w_shifted), w_nextKey);
    assign w_finalOut = add_round_key(w_shifted, w_nextKey);

    // State register for the FSM and all datapath registers
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            fsm_q    <= S_IDLE;
            state_q  <= '0;
            key_q    <= '0;
            rcon_q   <= '0;
            rc_q     <= '0;
            cipher_q <= '0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            key_q    <= key_d;
            rcon_q   <= rcon_d;
            rc_q     <= rc_d;
            cipher_q <= cipher_d;
        end
    end

    // Next-state logic: accept, nine full rounds, final round, hold result
    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        key_d    = key_q;
        rcon_d   = rcon_q;
        rc_d     = rc_q;
        cipher_d = cipher_q;
        case (fsm_q)
            S_IDLE: begin
                if (bus.inValid) begin
                    state_d = add_round_key(bus.plainIn, bus.keyIn);
                    key_d   = bus.keyIn;
                    rcon_d  = 8'h01;
                    rc_d    = 4'd1;
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = w_roundOut;
                key_d   = w_nextKey;
                rcon_d  = xtime(rcon_q);
                rc_d    = rc_q + 4'd1;
                if (rc_q == 4'd9) fsm_d = S_FINAL;
            end
            S_FINAL: begin
                state_d  = w_finalOut;
                key_d    = w_nextKey;
                rcon_d   = xtime(rcon_q);
                cipher_d = w_finalOut;
                rc_d     = 4'd0;
                fsm_d    = S_DONE;
            end
            S_DONE: begin
                if (bus.outReady) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    assign bus.inReady    = (fsm_q == S_IDLE);
    assign bus.outValid   = (fsm_q == S_DONE);
    assign bus.busy       = (fsm_q == S_ROUND) || (fsm_q == S_FINAL);
    assign bus.roundCount = rc_q;
    assign bus.cipherOut  = cipher_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_round_controller
//  Description : Directed scoreboard bench for aes_round_controller using the
//                FIPS-197 C.1 vector and the all-zero key/plaintext vector.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_round_controller;

    localparam logic [127:0] C_PT1 = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] C_K1  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] C_CT1 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] C_S0  = 128'hf0e0d0c0b0a090807060504030201000;
    localparam logic [127:0] C_CT0 = 128'h2e2b34ca59fa4c883b2c8aefd44be966;

    logic clock;
    logic nReset;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [127:0] sb_q[$];
    int           acc_q[$];
    int           rise_q[$];

    aes_round_controller_if bus ();

    aes_round_controller dut (
        .clock  (clock),
        .nReset (nReset),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.outValid && n < 40) begin
            tick();
            n++;
        end
        if (!bus.outValid) begin
            checks++;
            errors++;
            $display("FAIL %s: outValid timeout got 0 expected 1", tag);
        end
    endtask

    // Issue one block with outReady high and wait for its handshake.
    task automatic run_block(input string tag, input logic [127:0] pt,
                             input logic [127:0] key, input logic [127:0] exp);
        sb_q.push_back(exp);
        bus.outReady = 1'b1;
        bus.inValid  = 1'b1;
        bus.plainIn  = pt;
        bus.keyIn    = key;
        tick();
        bus.inValid  = 1'b0;
        bus.plainIn  = ~pt;
        bus.keyIn    = ~key;
        wait_valid(tag);
        tick();
        check({tag, "_outValid_drop"}, {127'd0, bus.outValid}, 128'd0);
        check({tag, "_inReady_rise"},  {127'd0, bus.inReady},  128'd1);
    endtask

    // Monitor: latency from accept, and ciphertext compare at each handshake
    initial begin : monitor
        logic       prev_v;
        logic [127:0] exp;
        prev_v = 1'b0;
        forever begin
            @(negedge clock);
            if (!nReset) begin
                acc_q.delete();
            end else begin
                if (bus.inValid && bus.inReady) acc_q.push_back(cyc + 1);
                if (bus.outValid && !prev_v) begin
                    rise_q.push_back(cyc);
                    if (acc_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL latency: got output with no accept expected accept first");
                    end else begin
                        check("latency", 128'(cyc), 128'(acc_q.pop_front() + 10));
                    end
                end
                if (bus.outValid && bus.outReady) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %h expected none", bus.cipherOut);
                    end else begin
                        exp = sb_q.pop_front();
                        check("cipher", bus.cipherOut, exp);
                    end
                end
            end
            prev_v = bus.outValid;
        end
    end

    initial begin
        int n;
        nReset       = 1'b0;
        bus.inValid  = 1'b0;
        bus.outReady = 1'b0;
        bus.plainIn  = '0;
        bus.keyIn    = '0;

        // Reset values
        repeat (3) tick();
        check("rst_inReady",    {127'd0, bus.inReady},  128'd1);
        check("rst_outValid",   {127'd0, bus.outValid}, 128'd0);
        check("rst_busy",       {127'd0, bus.busy},     128'd0);
        check("rst_roundCount", 128'(bus.roundCount),   128'd0);
        check("rst_cipherOut",  bus.cipherOut,          128'd0);
        nReset = 1'b1;
        tick();

        // FIPS-197 C.1 with round-by-round observation
        sb_q.push_back(C_CT1);
        bus.outReady = 1'b1;
        bus.inValid  = 1'b1;
        bus.plainIn  = C_PT1;
        bus.keyIn    = C_K1;
        tick();
        bus.inValid  = 1'b0;
        bus.plainIn  = 128'h0123456789abcdef0123456789abcdef;
        bus.keyIn    = 128'hfedcba9876543210fedcba9876543210;
        check("c1_state_e0", dut.state_q, C_S0);
        for (int k = 1; k <= 10; k++) begin
            check($sformatf("c1_roundCount_%0d", k), 128'(bus.roundCount), 128'(k));
            check($sformatf("c1_busy_%0d", k), {127'd0, bus.busy}, 128'd1);
            check($sformatf("c1_inReady_%0d", k), {127'd0, bus.inReady}, 128'd0);
            tick();
        end
        check("c1_outValid",   {127'd0, bus.outValid}, 128'd1);
        check("c1_roundCount", 128'(bus.roundCount),   128'd0);
        check("c1_busy",       {127'd0, bus.busy},     128'd0);
        tick();
        check("c1_outValid_drop", {127'd0, bus.outValid}, 128'd0);

        // All-zero vector
        run_block("zero", 128'd0, 128'd0, C_CT0);

        // Backpressure with an ignored request while busy/done
        sb_q.push_back(C_CT1);
        bus.outReady = 1'b0;
        bus.inValid  = 1'b1;
        bus.plainIn  = C_PT1;
        bus.keyIn    = C_K1;
        tick();
        bus.inValid  = 1'b0;
        tick();
        bus.inValid  = 1'b1;
        bus.plainIn  = 128'd0;
        bus.keyIn    = 128'd0;
        tick();
        bus.inValid  = 1'b0;
        wait_valid("bp");
        for (int k = 0; k < 5; k++) begin
            bus.inValid = (k % 2 == 0);
            check($sformatf("bp_cipher_%0d", k),  bus.cipherOut, C_CT1);
            check($sformatf("bp_outValid_%0d", k), {127'd0, bus.outValid}, 128'd1);
            check($sformatf("bp_inReady_%0d", k),  {127'd0, bus.inReady},  128'd0);
            tick();
        end
        bus.inValid  = 1'b0;
        bus.outReady = 1'b1;
        tick();
        check("bp_outValid_drop", {127'd0, bus.outValid}, 128'd0);
        check("bp_inReady_rise",  {127'd0, bus.inReady},  128'd1);
        repeat (3) tick();
        check("bp_not_taken", {127'd0, bus.busy}, 128'd0);

        // Back-to-back with inValid held high
        rise_q.delete();
        sb_q.push_back(C_CT1);
        sb_q.push_back(C_CT0);
        bus.inValid  = 1'b1;
        bus.plainIn  = C_PT1;
        bus.keyIn    = C_K1;
        tick();
        bus.plainIn  = 128'd0;
        bus.keyIn    = 128'd0;
        wait_valid("b2b_first");
        tick();
        tick();
        bus.inValid  = 1'b0;
        check("b2b_second_accept", {127'd0, bus.busy}, 128'd1);
        wait_valid("b2b_second");
        tick();
        if (rise_q.size() == 2) begin
            check("b2b_spacing", 128'(rise_q[1] - rise_q[0]), 128'd12);
        end else begin
            checks++;
            errors++;
            $display("FAIL b2b_outputs: got %0d outputs expected 2", rise_q.size());
        end

        // Reset in the middle of a block, then a clean rerun
        bus.inValid  = 1'b1;
        bus.plainIn  = C_PT1;
        bus.keyIn    = C_K1;
        tick();
        bus.inValid  = 1'b0;
        n = 0;
        while (bus.roundCount != 4'd5 && n < 20) begin
            tick();
            n++;
        end
        check("mid_reached_5", 128'(bus.roundCount), 128'd5);
        nReset = 1'b0;
        #1;
        check("mid_inReady",    {127'd0, bus.inReady},  128'd1);
        check("mid_outValid",   {127'd0, bus.outValid}, 128'd0);
        check("mid_busy",       {127'd0, bus.busy},     128'd0);
        check("mid_roundCount", 128'(bus.roundCount),   128'd0);
        check("mid_cipherOut",  bus.cipherOut,          128'd0);
        repeat (2) tick();
        nReset = 1'b1;
        tick();
        check("mid_no_output", {127'd0, bus.outValid}, 128'd0);
        run_block("rerun", C_PT1, C_K1, C_CT1);

        repeat (3) tick();
        check("scoreboard_empty", 128'(sb_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_round_controller.md
# aes_round_controller

Iterative AES-128 encryption sequencer: accepts one plaintext/key pair, runs the initial AddRoundKey plus ten rounds through the team's combinational round primitives (sub_bytes, shift_row, mix_columns, add_round_key), and generates each round key on the fly. It sits between the input-side handshake and the ciphertext consumer. It time-shares one round datapath across all rounds, one round per clock, so throughput is one block per 11+ cycles.

## Interface
- No parameters (AES-128 only; Nr = 10 fixed).
- clock  in  1  rising-edge clock
- nReset  in  1  asynchronous, active-low reset
- inValid  in  1  plaintext/key presented
- inReady  out  1  block idle, will accept on inValid
- plainIn  in  128  plaintext; AES state byte i at bits [8i+7:8i]
- keyIn  in  128  cipher key; key byte i at bits [8i+7:8i]
- outValid  out  1  ciphertext available
- outReady  in  1  consumer accepts ciphertext
- cipherOut  out  128  ciphertext, same byte order
- roundCount  out  4  current round index, 0 when idle/done
- busy  out  1  high in ROUND and FINAL states

## Operation
- States: IDLE, ROUND, FINAL, DONE.
- IDLE: inReady=1. On inValid&&inReady (accept edge E0): state reg <= plainIn ^ keyIn, roundKey reg <= keyIn, rcon <= 8'h01, roundCount <= 1, go ROUND.
- ROUND (roundCount 1..9): each edge computes next round key from roundKey and rcon (RotWord, SubWord, XOR rcon into key byte 0, word chain), state <= MixColumns(ShiftRows(SubBytes(state))) ^ nextKey, roundKey <= nextKey, rcon <= xtime(rcon) (wrap 8'h80 -> 8'h1b), roundCount += 1. Leaving round 9 -> FINAL.
- FINAL (roundCount 10): same but MixColumns bypassed; cipherOut register <= result; roundCount <= 0; go DONE.
- DONE: outValid=1, cipherOut stable. On outValid&&outReady -> IDLE.
- inValid outside IDLE ignored (inReady=0); plainIn/keyIn sampled only at E0 and may change afterwards.
- outReady outside DONE ignored.
- Byte order: byte i of the FIPS-197 column-major state is bits [8i+7:8i]; FIPS hex strings therefore appear byte-reversed on the ports.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, inReady=1, outValid=0, busy=0, roundCount=0, cipherOut=0, internal state/key/rcon regs=0.
- Latency: accept at edge E0; ROUND for edges E1..E9; FINAL at E10; outValid=1 in the cycle after E10.
- Output hold: outValid and cipherOut unchanged until the edge with outReady=1; outValid drops that edge; inReady=1 the same following cycle.
- Earliest next accept: edge after output handshake (min 12 cycles/block with outReady tied high).
- Reset mid-operation: any state returns immediately to reset values; partial result discarded, no outValid pulse.
- cipherOut is registered; no combinational path from inputs to any output except none (all outputs registered or state-decoded).

## Test plan
- Reset: hold nReset=0 for 3 cycles -> inReady=1, outValid=0, busy=0, roundCount=0, cipherOut=0.
- FIPS-197 C.1: plainIn=ffeeddccbbaa99887766554433221100, keyIn=0f0e0d0c0b0a09080706050403020100, inValid for 1 cycle, outReady=1 -> internal state after E0 = f0e0d0c0b0a090807060504030201000; roundCount 1..10 on successive cycles; outValid in cycle E10+1 with cipherOut=5ac5b47080b7cdd830047b6ad8e0c469.
- All-zero: plainIn=0, keyIn=0 -> cipherOut=2e2b34ca59fa4c883b2c8aefd44be966 after same latency.
- Backpressure/ignore: run C.1 with outReady=0 for 5 cycles after outValid, pulse inValid with other data while busy -> cipherOut stable 5ac5...c469 all 5 cycles, inReady=0, second request not taken; outReady=1 -> outValid drops, inReady rises.
- Back-to-back: C.1 then all-zero with inValid held high, outReady=1 -> two outputs in order, second accepted the edge after first handshake, 12-cycle spacing.
- Reset mid-op: assert nReset=0 when roundCount=5 -> all outputs to reset values at once, no outValid; rerun C.1 -> correct ciphertext.
